tacc_mm_sequencer: RTL

Command-driven sequencer for the tightly-coupled matrix-multiply accelerator. It accepts core commands (fill A, fill B, multiply, read, init), owns all row/column/k index counters, and time-multiplexes one shared multiply-accumulate path over external single-port A, B and result buffers. It sits between the core command/response interface and the buffer/MAC datapath. Every accepted command yields exactly one response.

---
 rtl/tacc_mm_sequencer_if.sv | 71 +++++++
 rtl/tacc_mm_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tacc_mm_sequencer_if.sv
// -----------------------------------------------------------------------------
// tacc_mm_sequencer_if
//
// Groups every signal of tacc_mm_sequencer except clk/rst.
//   Command side : cmd_val, busy, cmd_opcode, cmd_config_data
//   Response side: resp_val, resp_rdy, resp_data
//   A/B buffers  : a_wr_en, b_wr_en, wr_addr, wr_data,
//                  ab_rd_en, a_rd_addr, b_rd_addr, a_rd_data, b_rd_data
//   Result buffer: r_wr_en, r_wr_addr, r_wr_data,
//                  r_rd_en, r_rd_addr, r_rd_data
//
// Handshakes: a command is taken on a rising edge where cmd_val && !busy.
// A response completes on a rising edge where resp_val && resp_rdy.
// resp_val and resp_data hold their values until that edge.
// Buffer read data is valid in the cycle after the matching read strobe.
//
// Modports:
//   slave  : the sequencer. It drives busy, the response and all buffer
//            strobes, addresses and write data.
//   master : the core/buffer side. It drives the command, resp_rdy and the
//            buffer read data.
// -----------------------------------------------------------------------------
interface tacc_mm_sequencer_if #(
    parameter int DW = 64,
    parameter int AW = 8
);
    logic          cmd_val;
    logic          busy;
    logic [5:0]    cmd_opcode;
    logic [DW-1:0] cmd_config_data;

    logic          resp_val;
    logic          resp_rdy;
    logic [DW-1:0] resp_data;

    logic          a_wr_en;
    logic          b_wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          ab_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic [AW-1:0] b_rd_addr;
    logic [DW-1:0] a_rd_data;
    logic [DW-1:0] b_rd_data;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr;
    logic [DW-1:0] r_rd_data;

    modport slave (
        input  cmd_val, cmd_opcode, cmd_config_data, resp_rdy,
        input  a_rd_data, b_rd_data, r_rd_data,
        output busy, resp_val, resp_data,
        output a_wr_en, b_wr_en, wr_addr, wr_data,
        output ab_rd_en, a_rd_addr, b_rd_addr,
        output r_wr_en, r_wr_addr, r_wr_data, r_rd_en, r_rd_addr
    );

    modport master (
        output cmd_val, cmd_opcode, cmd_config_data, resp_rdy,
        output a_rd_data, b_rd_data, r_rd_data,
        input  busy, resp_val, resp_data,
        input  a_wr_en, b_wr_en, wr_addr, wr_data,
        input  ab_rd_en, a_rd_addr, b_rd_addr,
        input  r_wr_en, r_wr_addr, r_wr_data, r_rd_en, r_rd_addr
    );
endinterface

// File: rtl/tacc_mm_sequencer.sv
// -----------------------------------------------------------------------------
// tacc_mm_sequencer
//
// Command sequencer for the matrix-multiply accelerator. It takes fill A,
// fill B, multiply, read and init commands from the core. It owns every
// index counter, and it shares one multiply-accumulate path across the
// external single-port A, B and result buffers. Each accepted command
// produces exactly one response.
//
// Ports:
//   clk, rst  : clock; synchronous active-high reset
//   bus       : tacc_mm_sequencer_if.slave (command, response and all
//               buffer ports)
//   dbg_state : current FSM state, for observation only
//
// Buffers are N*N words, row-major, flat address = row*N + col.
// -----------------------------------------------------------------------------
module tacc_mm_sequencer #(
    parameter int N  = 10,
    parameter int DW = 64,
    parameter int AW = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    tacc_mm_sequencer_if.slave        bus,
    output logic [2:0]                dbg_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
    localparam logic [AW-1:0] N_AW      = AW'(N);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    localparam logic [5:0] OP_FILLA = 6'd0;
    localparam logic [5:0] OP_FILLB = 6'd1;
    localparam logic [5:0] OP_MULT  = 6'd2;
    localparam logic [5:0] OP_READ  = 6'd3;
    localparam logic [5:0] OP_INIT  = 6'd8;

    typedef enum logic [2:0] {
        IDLE, FILL, MUL, MUL_DRAIN, RD_WAIT, RD_CAP, RESP
    } state_t;

    state_t        state;
    logic [AW-1:0] fa_ptr, fb_ptr, rd_ptr;
    logic          fill_b;

    // Issue-side indices of the read currently on ab_rd_en.
    logic [IW-1:0] i_idx, j_idx, k_idx;
    logic [IW-1:0] ni, nj, nk;
    logic          issue_last;

    // Return side: the stage that aligns with a_rd_data/b_rd_data.
    logic          dv;
    logic          d_first;
    logic          d_last;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] acc;
    logic [DW-1:0] prod;
    logic [DW-1:0] acc_next;

    function automatic logic [AW-1:0] flat(input logic [IW-1:0] r,
                                           input logic [IW-1:0] c);
        return AW'(r) * N_AW + AW'(c);
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    assign bus.busy  = (state != IDLE);
    assign dbg_state = state;

    // Row-major walk over (i, j), with k innermost.
    always_comb begin
        ni = i_idx;
        nj = j_idx;
        nk = k_idx;
        if (k_idx == LAST_IDX) begin
            nk = '0;
            if (j_idx == LAST_IDX) begin
                nj = '0;
                ni = i_idx + 1'b1;
            end else begin
                nj = j_idx + 1'b1;
            end
        end else begin
            nk = k_idx + 1'b1;
        end
    end

    assign issue_last = (i_idx == LAST_IDX) && (j_idx == LAST_IDX) && (k_idx == LAST_IDX);

    // Only the low DW bits of the product are kept; the sum wraps mod 2^DW.
    assign prod     = bus.a_rd_data * bus.b_rd_data;
    assign acc_next = d_first ? prod : acc + prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fa_ptr        <= '0;
            fb_ptr        <= '0;
            rd_ptr        <= '0;
            fill_b        <= 1'b0;
            i_idx         <= '0;
            j_idx         <= '0;
            k_idx         <= '0;
            dv            <= 1'b0;
            d_first       <= 1'b0;
            d_last        <= 1'b0;
            d_addr        <= '0;
            acc           <= '0;
            bus.resp_val  <= 1'b0;
            bus.resp_data <= '0;
            bus.a_wr_en   <= 1'b0;
            bus.b_wr_en   <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.ab_rd_en  <= 1'b0;
            bus.a_rd_addr <= '0;
            bus.b_rd_addr <= '0;
            bus.r_wr_en   <= 1'b0;
            bus.r_wr_addr <= '0;
            bus.r_wr_data <= '0;
            bus.r_rd_en   <= 1'b0;
            bus.r_rd_addr <= '0;
        end else begin
            // Single-cycle strobes fall back to 0 unless a state below sets them.
            bus.a_wr_en <= 1'b0;
            bus.b_wr_en <= 1'b0;
            bus.r_wr_en <= 1'b0;
            bus.r_rd_en <= 1'b0;

            // The return stage tracks the issue stage, one cycle behind.
            dv      <= bus.ab_rd_en;
            d_first <= (k_idx == '0);
            d_last  <= (k_idx == LAST_IDX);
            d_addr  <= flat(i_idx, j_idx);

            if (dv) begin
                acc <= acc_next;
                if (d_last) begin
                    bus.r_wr_en   <= 1'b1;
                    bus.r_wr_addr <= d_addr;
                    bus.r_wr_data <= acc_next;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.cmd_val) begin
                        case (bus.cmd_opcode)
                            OP_FILLA, OP_FILLB: begin
                                fill_b      <= (bus.cmd_opcode == OP_FILLB);
                                bus.a_wr_en <= (bus.cmd_opcode == OP_FILLA);
                                bus.b_wr_en <= (bus.cmd_opcode == OP_FILLB);
                                bus.wr_addr <= (bus.cmd_opcode == OP_FILLB) ? fb_ptr : fa_ptr;
                                bus.wr_data <= bus.cmd_config_data;
                                state       <= FILL;
                            end
                            OP_MULT: begin
                                i_idx         <= '0;
                                j_idx         <= '0;
                                k_idx         <= '0;
                                bus.ab_rd_en  <= 1'b1;
                                bus.a_rd_addr <= '0;
                                bus.b_rd_addr <= '0;
                                state         <= MUL;
                            end
                            OP_READ: begin
                                bus.r_rd_en   <= 1'b1;
                                bus.r_rd_addr <= rd_ptr;
                                state         <= RD_WAIT;
                            end
                            OP_INIT: begin
                                fa_ptr        <= '0;
                                fb_ptr        <= '0;
                                rd_ptr        <= '0;
                                acc           <= '0;
                                bus.resp_data <= '0;
                                bus.resp_val  <= 1'b1;
                                state         <= RESP;
                            end
                            default: begin
                                bus.resp_data <= '0;
                                bus.resp_val  <= 1'b1;
                                state         <= RESP;
                            end
                        endcase
                    end
                end
                FILL: begin
                    if (fill_b) fb_ptr <= ptr_inc(fb_ptr);
                    else        fa_ptr <= ptr_inc(fa_ptr);
                    bus.resp_data <= DW'(bus.wr_addr);
                    bus.resp_val  <= 1'b1;
                    state         <= RESP;
                end
                MUL: begin
                    // The read addresses are issued back to back, with no
                    // gap between output elements.
                    if (issue_last) begin
                        bus.ab_rd_en <= 1'b0;
                        state        <= MUL_DRAIN;
                    end else begin
                        i_idx         <= ni;
                        j_idx         <= nj;
                        k_idx         <= nk;
                        bus.a_rd_addr <= flat(ni, nk);
                        bus.b_rd_addr <= flat(nk, nj);
                    end
                end
                MUL_DRAIN: begin
                    // During the drain, the only write strobe is the final element's.
                    if (bus.r_wr_en) begin
                        bus.resp_data <= DW'(N * N);
                        bus.resp_val  <= 1'b1;
                        state         <= RESP;
                    end
                end
                RD_WAIT: begin
                    rd_ptr <= ptr_inc(rd_ptr);
                    state  <= RD_CAP;
                end
                RD_CAP: begin
                    bus.resp_data <= bus.r_rd_data;
                    bus.resp_val  <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.resp_rdy) begin
                        bus.resp_val <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
